// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg -- shared definitions for the EX pipeline stage.
//
// Contents:
//   DATA_W / REG_W   : datapath and register-index widths
//   aluop_e          : 2-bit ALU operation class driven by the ID stage
//   FUNCT_*          : R-type funct field values understood by the ALU
//   alu_ctl_e        : decoded ALU operation
//   ex_state_e       : EX stage sequencing state (iterative multiply)
//   ex_mem_t         : bundle of EX/MEM pipeline register contents
//   alu_decode()     : aluOp + funct -> alu_ctl_e
//
// The multiplier states are only used when EX_MULT_EN is defined.
// -----------------------------------------------------------------------------
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL,
        ALU_NONE
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_BUSY,
        ST_MUL_DONE
    } ex_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] writeData;
        logic [REG_W-1:0]  writeReg;
        logic              zero;
        logic [2:0]        memCtl;
        logic [1:0]        wbCtl;
    } ex_mem_t;

    // The reserved aluOp encoding behaves as add.
    function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [5:0] funct);
        alu_ctl_e ctl;
        case (aluop_e'(op))
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  ctl = ALU_ADD;
                    FUNCT_SUB:  ctl = ALU_SUB;
                    FUNCT_AND:  ctl = ALU_AND;
                    FUNCT_OR:   ctl = ALU_OR;
                    FUNCT_SLT:  ctl = ALU_SLT;
                    FUNCT_MULT: ctl = ALU_MUL;
                    default:    ctl = ALU_NONE;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter -- 32-step shift-add multiplier producing the low word of a*b.
// Present only when EX_MULT_EN is defined.
//
// Ports:
//   clock, resetN : clock, asynchronous active-low reset
//   i_start       : capture operands, clear accumulator and step counter
//   i_abort       : abandon any multiply in progress
//   i_a, i_b      : multiplicand / multiplier
//   o_done        : final step happens on the coming edge; o_product is
//                   complete from the cycle after
//   o_product     : low 32 bits of the product
// -----------------------------------------------------------------------------
`ifdef EX_MULT_EN
module mul_iter
    import ex_pkg::*;
(
    input  logic              clock,
    input  logic              resetN,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    logic              r_busy;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            // Bits shifted out above bit 31 never reach the low word.
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= {r_mcand[DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
            // Counter parks at 31 instead of wrapping.
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign o_done    = r_busy && (r_cnt == 5'd31);
    assign o_product = r_acc;

endmodule
`endif

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage -- execute stage: ALU, destination select, EX/MEM register.
//
// Inputs : clock, resetN (async, active-low), regDest, aluSrc, aluOp[1:0],
//          memControl[2:0], wbControl[1:0], readData1/readData2/
//          signExtendWire[31:0], rd/rt[4:0], flush
// Outputs: stall (combinational), and registered aluResult, writeData,
//          writeReg, zero, memControlExMem, wbControlExMem
//
// Build option EX_MULT_EN: adds the iterative multiplier (mul_iter) for
// funct 0x18. The stage stalls upstream for 33 cycles and emits bubbles
// while it runs. Without it, mult returns 0 in one cycle and stall is 0.
// -----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
(
    input  logic              clock,
    input  logic              resetN,
    input  logic              regDest,
    input  logic              aluSrc,
    input  logic [1:0]        aluOp,
    input  logic [2:0]        memControl,
    input  logic [1:0]        wbControl,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] signExtendWire,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rt,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] writeData,
    output logic [REG_W-1:0]  writeReg,
    output logic              zero,
    output logic [2:0]        memControlExMem,
    output logic [1:0]        wbControlExMem
);

    function automatic logic [DATA_W-1:0] alu_compute(input alu_ctl_e ctl,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        res;
        sa = a;
        sb = b;
        case (ctl)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {{(DATA_W-1){1'b0}}, (sa < sb)};
            default: res = '0;
        endcase
        return res;
    endfunction

    alu_ctl_e          w_aluCtl;
    logic [DATA_W-1:0] w_opB;
    logic [DATA_W-1:0] w_result;
    ex_mem_t           w_normal;
    ex_mem_t           r_out;

    always_comb begin
        w_aluCtl = alu_decode(aluOp, signExtendWire[5:0]);
        w_opB    = aluSrc ? signExtendWire : readData2;
        w_result = alu_compute(w_aluCtl, readData1, w_opB);

        w_normal           = '0;
        w_normal.aluResult = w_result;
        w_normal.writeData = readData2;
        w_normal.writeReg  = regDest ? rd : rt;
        w_normal.zero      = (w_result == '0);
        w_normal.memCtl    = memControl;
        w_normal.wbCtl     = wbControl;
    end

`ifdef EX_MULT_EN
    ex_state_e         r_state;
    logic              w_isMult;
    logic              w_mulStart;
    logic              w_mulDone;
    logic [DATA_W-1:0] w_product;
    ex_mem_t           w_mulOut;
    logic [DATA_W-1:0] r_holdData;
    logic [REG_W-1:0]  r_holdReg;
    logic [2:0]        r_holdMem;
    logic [1:0]        r_holdWb;

    assign w_isMult   = (w_aluCtl == ALU_MUL);
    assign w_mulStart = (r_state == ST_IDLE) && w_isMult && !flush;
    // Gated by resetN so upstream is released immediately during reset.
    assign stall      = resetN && (w_mulStart || ((r_state == ST_MUL_BUSY) && !flush));

    mul_iter u_mul_iter (
        .clock     (clock),
        .resetN    (resetN),
        .i_start   (w_mulStart),
        .i_abort   (flush),
        .i_a       (readData1),
        .i_b       (w_opB),
        .o_done    (w_mulDone),
        .o_product (w_product)
    );

    // Controls of the multiply, latched at start and replayed with the product.
    always_ff @(posedge clock) begin
        if (w_mulStart) begin
            r_holdData <= readData2;
            r_holdReg  <= regDest ? rd : rt;
            r_holdMem  <= memControl;
            r_holdWb   <= wbControl;
        end
    end

    always_comb begin
        w_mulOut           = '0;
        w_mulOut.aluResult = w_product;
        w_mulOut.writeData = r_holdData;
        w_mulOut.writeReg  = r_holdReg;
        w_mulOut.zero      = (w_product == '0);
        w_mulOut.memCtl    = r_holdMem;
        w_mulOut.wbCtl     = r_holdWb;
    end

    // EX/MEM register and sequencing; an all-zero bundle is a bubble.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_isMult) begin
                        r_state <= ST_MUL_BUSY;
                        r_out   <= '0;
                    end else begin
                        r_out <= w_normal;
                    end
                end
                ST_MUL_BUSY: begin
                    r_out <= '0;
                    if (w_mulDone) begin
                        r_state <= ST_MUL_DONE;
                    end
                end
                ST_MUL_DONE: begin
                    r_state <= ST_IDLE;
                    r_out   <= w_mulOut;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end
`else
    assign stall = 1'b0;

    // EX/MEM register; an all-zero bundle is a bubble.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_out <= '0;
        end else if (flush) begin
            r_out <= '0;
        end else begin
            r_out <= w_normal;
        end
    end
`endif

    assign aluResult       = r_out.aluResult;
    assign writeData       = r_out.writeData;
    assign writeReg        = r_out.writeReg;
    assign zero            = r_out.zero;
    assign memControlExMem = r_out.memCtl;
    assign wbControlExMem  = r_out.wbCtl;

endmodule
